hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM producers, generates stall/flush/bubble
// controls and registered operand-forwarding selects. Optional forwarding: HAZARD_CTRL_FORWARDING_EN.
module hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic              i_id_reg_w_en,
  input  logic              i_id_mem_r_en,
  input  logic              i_ex_redirect,
  input  logic              i_mem_stall,
  output logic              o_stall_if,
  output logic              o_stall_id,
  output logic              o_flush_id,
  output logic              o_bubble_ex,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_w_en;
    logic              mem_r_en;
  } stage_t;

  stage_t           ex_q;
  stage_t           mem_q;
  stage_t           id_entry;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             hazard;
  logic             hazard_stall;

  // x0 is hard-wired, so it never creates a dependency.
  function automatic logic hits(input stage_t e, input logic [REG_AW-1:0] rs,
                                input logic in_use, input logic loads_only);
    return e.valid && e.reg_w_en && (e.mem_r_en || !loads_only) &&
           in_use && (rs != '0) && (e.rd == rs);
  endfunction

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = i_id_valid;
    id_entry.rd       = i_id_rd;
    id_entry.reg_w_en = i_id_reg_w_en;
    id_entry.mem_r_en = i_id_mem_r_en;
  end

`ifdef HAZARD_CTRL_FORWARDING_EN
  // Only a load still in EX cannot be forwarded in time.
  always_comb begin
    hazard = 1'b0;
    if (i_id_valid)
      hazard = hits(ex_q, i_id_rs1, i_id_use_rs1, 1'b1) ||
               hits(ex_q, i_id_rs2, i_id_use_rs2, 1'b1);
  end
`else
  always_comb begin
    hazard = 1'b0;
    if (i_id_valid)
      hazard = hits(ex_q,  i_id_rs1, i_id_use_rs1, 1'b0) ||
               hits(ex_q,  i_id_rs2, i_id_use_rs2, 1'b0) ||
               hits(mem_q, i_id_rs1, i_id_use_rs1, 1'b0) ||
               hits(mem_q, i_id_rs2, i_id_use_rs2, 1'b0);
  end
`endif

  // Priority: reset, then freeze, then redirect, then data hazard.
  always_comb begin
    o_stall_if   = 1'b0;
    o_stall_id   = 1'b0;
    o_flush_id   = 1'b0;
    o_bubble_ex  = 1'b0;
    hazard_stall = 1'b0;
    if (!i_rst) begin
      if (i_mem_stall) begin
        o_stall_if = 1'b1;
        o_stall_id = 1'b1;
      end else if (i_ex_redirect) begin
        o_flush_id  = 1'b1;
        o_bubble_ex = 1'b1;
      end else if (hazard) begin
        o_stall_if   = 1'b1;
        o_stall_id   = 1'b1;
        o_bubble_ex  = 1'b1;
        hazard_stall = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      stall_cnt_q <= '0;
    end else if (!i_mem_stall) begin
      mem_q <= ex_q;
      ex_q  <= o_bubble_ex ? '0 : id_entry;
      if (hazard_stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign o_stall_cnt = stall_cnt_q;

`ifdef HAZARD_CTRL_FORWARDING_EN
  logic [1:0] fwd_a_q;
  logic [1:0] fwd_b_q;

  // Selects are computed for the ID instruction and take effect once it reaches EX:
  // today's EX producer will sit in MEM (01), today's MEM producer in WB (10).
  function automatic logic [1:0] fwd_sel(input stage_t ex_e, input stage_t mem_e,
                                         input logic [REG_AW-1:0] rs, input logic in_use);
    if (hits(ex_e, rs, in_use, 1'b0))
      return 2'b01;
    else if (hits(mem_e, rs, in_use, 1'b0))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else if (!i_mem_stall) begin
      if (o_bubble_ex || !i_id_valid) begin
        fwd_a_q <= '0;
        fwd_b_q <= '0;
      end else begin
        fwd_a_q <= fwd_sel(ex_q, mem_q, i_id_rs1, i_id_use_rs1);
        fwd_b_q <= fwd_sel(ex_q, mem_q, i_id_rs2, i_id_use_rs2);
      end
    end
  end

  assign o_fwd_a = fwd_a_q;
  assign o_fwd_b = fwd_b_q;
`else
  assign o_fwd_a = '0;
  assign o_fwd_b = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a behavioural pipeline model predicts every cycle's
// outputs, a negedge monitor compares them against the DUT.
module tb_hazard_ctrl;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, id_valid, use_rs1, use_rs2, reg_w_en, mem_r_en, redirect, mem_stall;
  logic [4:0]       rs1, rs2, rd;
  logic             stall_if, stall_id, flush_id, bubble_ex;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rd(rd),
    .i_id_use_rs1(use_rs1), .i_id_use_rs2(use_rs2),
    .i_id_reg_w_en(reg_w_en), .i_id_mem_r_en(mem_r_en),
    .i_ex_redirect(redirect), .i_mem_stall(mem_stall),
    .o_stall_if(stall_if), .o_stall_id(stall_id), .o_flush_id(flush_id),
    .o_bubble_ex(bubble_ex), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_stall_cnt(stall_cnt)
  );

  typedef struct {
    logic v; logic [4:0] rs1, rs2, rd; logic u1, u2, w, l;
  } ins_t;

  // An instruction in flight, carrying the forwarding selects it was issued with.
  typedef struct {
    logic v; logic [4:0] rd; logic w, l; logic [1:0] fa, fb;
  } ent_t;

  typedef struct {
    logic sif, sid, fl, bub; logic [1:0] fa, fb; int cnt; bit chk_state;
  } exp_t;

  ent_t pipe[$];   // [0] = instruction in EX, [1] = instruction in MEM
  exp_t sb[$];
  int   m_cnt;
  bit   m_known = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic ent_t bubble();
    ent_t b;
    b = '{v: 1'b0, rd: 5'd0, w: 1'b0, l: 1'b0, fa: 2'b00, fb: 2'b00};
    return b;
  endfunction

  // Age of the youngest in-flight writer of rs (0 = EX, 1 = MEM), -1 if none.
  function automatic int youngest(input logic [4:0] rs, input logic in_use);
    for (int age = 0; age < 2; age++)
      if (in_use && rs != 0 && pipe[age].v && pipe[age].w && pipe[age].rd == rs)
        return age;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step(input logic r, input ins_t in, input logic redir, input logic mst,
                      output logic stalled);
    exp_t e;
    int   ya, yb;
    logic haz;
    ent_t nu;
    e = '{sif: 0, sid: 0, fl: 0, bub: 0, fa: 2'b00, fb: 2'b00, cnt: 0, chk_state: m_known};
    if (m_known) begin
      e.fa  = pipe[0].fa;
      e.fb  = pipe[0].fb;
      e.cnt = m_cnt;
    end
    ya = youngest(in.rs1, in.u1);
    yb = youngest(in.rs2, in.u2);
`ifdef HAZARD_CTRL_FORWARDING_EN
    haz = in.v && ((ya == 0 && pipe[0].l) || (yb == 0 && pipe[0].l));
`else
    haz = in.v && (ya >= 0 || yb >= 0);
`endif
    if (r) begin
      pipe = {};
      pipe.push_back(bubble());
      pipe.push_back(bubble());
      m_cnt   = 0;
      m_known = 1;
    end else if (mst) begin
      e.sif = 1;
      e.sid = 1;
    end else begin
      if (redir) begin
        e.fl  = 1;
        e.bub = 1;
      end else if (haz) begin
        e.sif = 1;
        e.sid = 1;
        e.bub = 1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      if (e.bub) nu = bubble();
      else begin
        nu = '{v: in.v, rd: in.rd, w: in.w, l: in.l, fa: 2'b00, fb: 2'b00};
`ifdef HAZARD_CTRL_FORWARDING_EN
        if (in.v) begin
          nu.fa = (ya < 0) ? 2'b00 : 2'(ya + 1);
          nu.fb = (yb < 0) ? 2'b00 : 2'(yb + 1);
        end
`endif
      end
      pipe.push_front(nu);
      void'(pipe.pop_back());
    end
    sb.push_back(e);
    stalled = e.sid;
  endtask

  task automatic cyc(input logic r, input ins_t in, input logic redir, input logic mst,
                     output logic stalled);
    @(posedge clk);
    #1;
    rst = r; id_valid = in.v; rs1 = in.rs1; rs2 = in.rs2; rd = in.rd;
    use_rs1 = in.u1; use_rs2 = in.u2; reg_w_en = in.w; mem_r_en = in.l;
    redirect = redir; mem_stall = mst;
    step(r, in, redir, mst, stalled);
  endtask

  // Present an instruction in ID and hold it there while the model says it is stalled.
  task automatic issue(input ins_t in);
    logic st;
    int   n;
    n = 0;
    do begin
      cyc(1'b0, in, 1'b0, 1'b0, st);
      n++;
    end while (st && n < 8);
  endtask

  function automatic ins_t mk(input logic [4:0] a, input logic [4:0] b, input logic ua,
                              input logic ub, input logic [4:0] d, input logic w, input logic l);
    ins_t i;
    i = '{v: 1'b1, rs1: a, rs2: b, rd: d, u1: ua, u2: ub, w: w, l: l};
    return i;
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i = '{v: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, u1: 1'b0, u2: 1'b0, w: 1'b0, l: 1'b0};
    return i;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("stall_if", 32'(stall_if), 32'(e.sif));
      chk("stall_id", 32'(stall_id), 32'(e.sid));
      chk("flush_id", 32'(flush_id), 32'(e.fl));
      chk("bubble_ex", 32'(bubble_ex), 32'(e.bub));
      if (e.chk_state) begin
        chk("fwd_a", 32'(fwd_a), 32'(e.fa));
        chk("fwd_b", 32'(fwd_b), 32'(e.fb));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic st;
    ins_t cur;
    bit   held;
    rst = 1; id_valid = 0; rs1 = 0; rs2 = 0; rd = 0; use_rs1 = 0; use_rs2 = 0;
    reg_w_en = 0; mem_r_en = 0; redirect = 0; mem_stall = 0;
    pipe.push_back(bubble());
    pipe.push_back(bubble());

    cyc(1'b1, nop(), 1'b0, 1'b0, st);
    cyc(1'b1, nop(), 1'b1, 1'b1, st);   // reset dominates redirect and freeze
    issue(nop());

    // ALU write x5, immediate rs1 consumer
    issue(mk(5'd1, 5'd2, 1, 1, 5'd5, 1, 0));
    issue(mk(5'd5, 5'd3, 1, 1, 5'd9, 1, 0));
    issue(nop()); issue(nop());

    // load x6, rs2 consumer
    issue(mk(5'd1, 5'd0, 1, 0, 5'd6, 1, 1));
    issue(mk(5'd4, 5'd6, 1, 1, 5'd10, 1, 0));
    issue(nop()); issue(nop());

    // ALU write x7, consumer on both operands, EX and MEM producers of same reg
    issue(mk(5'd1, 5'd2, 1, 1, 5'd7, 1, 0));
    issue(mk(5'd3, 5'd4, 1, 1, 5'd7, 1, 0));
    issue(mk(5'd7, 5'd7, 1, 1, 5'd11, 1, 0));
    issue(nop()); issue(nop());

    // load x8 with load-use consumer and a redirect in the same cycle
    issue(mk(5'd1, 5'd0, 1, 0, 5'd8, 1, 1));
    cyc(1'b0, mk(5'd8, 5'd0, 1, 0, 5'd12, 1, 0), 1'b1, 1'b0, st);
    issue(nop()); issue(nop());

    // freeze for 3 cycles in the middle of a load-use stall
    issue(mk(5'd1, 5'd0, 1, 0, 5'd6, 1, 1));
    cyc(1'b0, mk(5'd6, 5'd0, 1, 0, 5'd13, 1, 0), 1'b0, 1'b0, st);
    repeat (3) cyc(1'b0, mk(5'd6, 5'd0, 1, 0, 5'd13, 1, 0), 1'b0, 1'b1, st);
    issue(mk(5'd6, 5'd0, 1, 0, 5'd13, 1, 0));
    issue(nop()); issue(nop());

    // x0 producer and consumer, unused-source match
    issue(mk(5'd1, 5'd0, 1, 0, 5'd0, 1, 1));
    issue(mk(5'd0, 5'd0, 1, 1, 5'd14, 1, 0));
    issue(mk(5'd1, 5'd0, 1, 0, 5'd15, 1, 1));
    issue(mk(5'd15, 5'd15, 0, 0, 5'd16, 1, 0));
    issue(nop()); issue(nop());

    // reset in the middle of a stall
    issue(mk(5'd1, 5'd0, 1, 0, 5'd7, 1, 1));
    cyc(1'b0, mk(5'd7, 5'd0, 1, 0, 5'd17, 1, 0), 1'b0, 1'b0, st);
    cyc(1'b1, mk(5'd7, 5'd0, 1, 0, 5'd17, 1, 0), 1'b0, 1'b0, st);
    issue(mk(5'd7, 5'd0, 1, 0, 5'd17, 1, 0));

    // counter saturation
    for (int k = 0; k < 20; k++) begin
      issue(mk(5'd1, 5'd0, 1, 0, 5'd3, 1, 1));
      issue(mk(5'd3, 5'd3, 1, 1, 5'd4, 1, 0));
    end
    issue(nop());

    // randomized traffic over a small register set to provoke dependencies
    held = 0;
    cur  = nop();
    for (int k = 0; k < 600; k++) begin
      logic r, rdr, ms;
      if (!held) begin
        cur.v   = ($urandom_range(0, 9) != 0);
        cur.rs1 = 5'($urandom_range(0, 3));
        cur.rs2 = 5'($urandom_range(0, 3));
        cur.rd  = 5'($urandom_range(0, 3));
        cur.u1  = 1'($urandom_range(0, 1));
        cur.u2  = 1'($urandom_range(0, 1));
        cur.w   = ($urandom_range(0, 3) != 0);
        cur.l   = 1'($urandom_range(0, 1));
      end
      r   = ($urandom_range(0, 59) == 0);
      rdr = ($urandom_range(0, 9) == 0);
      ms  = ($urandom_range(0, 9) == 0);
      cyc(r, cur, rdr, ms, st);
      held = st;
    end
    issue(nop());

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
